// File: rtl/vend_dispense_ctrl.sv
// Actuator stage behind the vending FSM: queues drop/change pulses and drives chute
// solenoids and hopper motors one at a time, each closed-loop on a sensor with a timeout.

module vend_prod_lane #(
   parameter int STOCK_INIT = 8,
   parameter int STOCK_W    = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic drop,
   input  logic done,
   input  logic restock,
   output logic pend,
   output logic pend_nxt,
   output logic stock_ok
);
   logic [STOCK_W-1:0] stock, stock_nxt;

   // restock overrides a same-cycle decrement
   always_comb begin
      stock_nxt = stock;
      if (restock)
         stock_nxt = STOCK_W'(STOCK_INIT);
      else if (done && stock != '0)
         stock_nxt = stock - STOCK_W'(1);
   end

   always_comb begin
      pend_nxt = pend;
      if (done)
         pend_nxt = 1'b0;
      else if (drop && stock != '0)
         pend_nxt = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stock    <= STOCK_W'(STOCK_INIT);
         pend     <= 1'b0;
         stock_ok <= 1'b1;
      end else begin
         stock    <= stock_nxt;
         pend     <= pend_nxt;
         stock_ok <= (stock_nxt != '0);
      end
   end
endmodule

module vend_dispense_ctrl #(
   parameter int STOCK_INIT = 8,
   parameter int STOCK_W    = 4,
   parameter int PEND_W     = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic drop_water,
   input  logic drop_coke,
   input  logic drop_coffee,
   input  logic change5,
   input  logic change10,
   input  logic prod_sense,
   input  logic coin_sense,
   input  logic restock,
   input  logic clear_fault,
   output logic vend_water,
   output logic vend_coke,
   output logic vend_coffee,
   output logic motor5,
   output logic motor10,
   output logic stock_ok_water,
   output logic stock_ok_coke,
   output logic stock_ok_coffee,
   output logic busy,
   output logic fault
);
   localparam int NUM_P = 3;
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_VEND, S_COIN10, S_COIN5, S_GAP, S_FAULT} state_t;

   state_t             state, state_nxt;
   logic [1:0]         prod, prod_nxt;
   logic [TMR_W-1:0]   timer, timer_nxt;
   logic [PEND_W-1:0]  pend5, pend10, pend5_nxt, pend10_nxt;
   logic               ovf5, ovf10, done5, done10, tmo;
   logic [NUM_P-1:0]   drop_v, done_v, pend_v, pend_nxt_v, stock_ok_v;
   logic [NUM_P-1:0]   vend_d, vend_q;
   logic               motor5_d, motor10_d, busy_d, fault_d;

   assign drop_v = {drop_coffee, drop_coke, drop_water};

   for (genvar i = 0; i < NUM_P; i++) begin : g_lane
      assign done_v[i] = (state == S_VEND) && prod_sense && (prod == 2'(i));
      vend_prod_lane #(.STOCK_INIT(STOCK_INIT), .STOCK_W(STOCK_W)) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .drop     (drop_v[i]),
         .done     (done_v[i]),
         .restock  (restock),
         .pend     (pend_v[i]),
         .pend_nxt (pend_nxt_v[i]),
         .stock_ok (stock_ok_v[i])
      );
   end

   assign done10 = (state == S_COIN10) && coin_sense;
   assign done5  = (state == S_COIN5)  && coin_sense;
   assign tmo    = (timer == TMR_W'(TIMEOUT - 1));

   // {overflow, next}: an increment at all-ones is dropped and flagged
   function automatic logic [PEND_W:0] pend_step(input logic [PEND_W-1:0] cnt,
                                                 input logic inc, input logic dec);
      logic [PEND_W:0] r;
      r = {1'b0, cnt};
      if (inc && !dec) begin
         if (cnt == '1) r[PEND_W] = 1'b1;
         else           r = {1'b0, cnt + PEND_W'(1)};
      end else if (dec && !inc) begin
         r = {1'b0, cnt - PEND_W'(1)};
      end
      return r;
   endfunction

   always_comb begin
      {ovf10, pend10_nxt} = pend_step(pend10, change10, done10);
      {ovf5,  pend5_nxt}  = pend_step(pend5,  change5,  done5);
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         prod   <= '0;
         timer  <= '0;
         pend5  <= '0;
         pend10 <= '0;
      end else begin
         state  <= state_nxt;
         prod   <= prod_nxt;
         timer  <= timer_nxt;
         pend5  <= pend5_nxt;
         pend10 <= pend10_nxt;
      end
   end

   // next state
   always_comb begin
      state_nxt = state;
      prod_nxt  = prod;
      timer_nxt = '0;
      case (state)
         S_IDLE: begin
            if (pend_v[0]) begin
               state_nxt = S_VEND; prod_nxt = 2'd0;
            end else if (pend_v[1]) begin
               state_nxt = S_VEND; prod_nxt = 2'd1;
            end else if (pend_v[2]) begin
               state_nxt = S_VEND; prod_nxt = 2'd2;
            end else if (pend10 != '0) begin
               state_nxt = S_COIN10;
            end else if (pend5 != '0) begin
               state_nxt = S_COIN5;
            end
         end
         S_VEND: begin
            if (prod_sense) state_nxt = S_GAP;
            else if (tmo)   state_nxt = S_FAULT;
         end
         S_COIN10, S_COIN5: begin
            if (coin_sense) state_nxt = S_GAP;
            else if (tmo)   state_nxt = S_FAULT;
         end
         S_GAP:   state_nxt = S_IDLE;
         S_FAULT: if (clear_fault) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (ovf5 || ovf10) state_nxt = S_FAULT;
      if (state_nxt == state &&
          (state == S_VEND || state == S_COIN10 || state == S_COIN5))
         timer_nxt = timer + TMR_W'(1);
   end

   // outputs are registered from the next state so actuators track the state exactly
   always_comb begin
      vend_d = '0;
      for (int i = 0; i < NUM_P; i++)
         vend_d[i] = (state_nxt == S_VEND) && (prod_nxt == 2'(i));
      motor10_d = (state_nxt == S_COIN10);
      motor5_d  = (state_nxt == S_COIN5);
      fault_d   = (state_nxt == S_FAULT);
      busy_d    = (state_nxt != S_IDLE) || (|pend_nxt_v) ||
                  (pend5_nxt != '0) || (pend10_nxt != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vend_q  <= '0;
         motor10 <= 1'b0;
         motor5  <= 1'b0;
         fault   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         vend_q  <= vend_d;
         motor10 <= motor10_d;
         motor5  <= motor5_d;
         fault   <= fault_d;
         busy    <= busy_d;
      end
   end

   assign vend_water      = vend_q[0];
   assign vend_coke       = vend_q[1];
   assign vend_coffee     = vend_q[2];
   assign stock_ok_water  = stock_ok_v[0];
   assign stock_ok_coke   = stock_ok_v[1];
   assign stock_ok_coffee = stock_ok_v[2];
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: dispense, coin order, sell-out, timeout/fault,
// pend saturation, async reset and restock race.

module tb_vend_dispense_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic drop_water = 0, drop_coke = 0, drop_coffee = 0;
   logic change5 = 0, change10 = 0, prod_sense = 0, coin_sense = 0;
   logic restock = 0, clear_fault = 0;
   logic vend_water, vend_coke, vend_coffee, motor5, motor10;
   logic stock_ok_water, stock_ok_coke, stock_ok_coffee, busy, fault;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   vend_dispense_ctrl #(.STOCK_INIT(8), .STOCK_W(4), .PEND_W(4), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .drop_water(drop_water), .drop_coke(drop_coke), .drop_coffee(drop_coffee),
      .change5(change5), .change10(change10),
      .prod_sense(prod_sense), .coin_sense(coin_sense),
      .restock(restock), .clear_fault(clear_fault),
      .vend_water(vend_water), .vend_coke(vend_coke), .vend_coffee(vend_coffee),
      .motor5(motor5), .motor10(motor10),
      .stock_ok_water(stock_ok_water), .stock_ok_coke(stock_ok_coke),
      .stock_ok_coffee(stock_ok_coffee),
      .busy(busy), .fault(fault)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic act(input int w);
      case (w)
         0:       return vend_water;
         1:       return vend_coke;
         default: return vend_coffee;
      endcase
   endfunction

   // one full dispense: sense on the third actuator cycle, optionally with restock
   task automatic vend_one(input int w, input bit rs, output bit ok);
      int n;
      ok = 1'b1;
      case (w)
         0:       drop_water  = 1;
         1:       drop_coke   = 1;
         default: drop_coffee = 1;
      endcase
      tick();
      drop_water = 0; drop_coke = 0; drop_coffee = 0;
      n = 0;
      while (!act(w) && n < 10) begin tick(); n++; end
      if (!act(w)) begin ok = 1'b0; return; end
      tick(); tick();
      prod_sense = 1; restock = rs;
      tick();
      prod_sense = 0; restock = 0;
      n = 0;
      while (busy && n < 10) begin tick(); n++; end
      if (busy) ok = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({vend_water, vend_coke, vend_coffee, motor5, motor10, busy, fault} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 0000000",
                  {vend_water, vend_coke, vend_coffee, motor5, motor10, busy, fault});
      end
      n_checks++;
      if ({stock_ok_water, stock_ok_coke, stock_ok_coffee} !== 3'b111) begin
         n_fail++;
         $display("FAIL reset_stock_ok: got %b want 111",
                  {stock_ok_water, stock_ok_coke, stock_ok_coffee});
      end
      @(negedge clk);
      rst_n = 1;
      tick();
   endtask

   task automatic test_water_dispense();
      int on_bad;
      drop_water = 1;
      tick();
      drop_water = 0;
      n_checks++;
      if (busy !== 1'b1 || vend_water !== 1'b0) begin
         n_fail++;
         $display("FAIL water_queued: busy=%b vend_water=%b want 1 0", busy, vend_water);
      end
      tick();
      on_bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (vend_water !== 1'b1) on_bad++;
         if (i == 3) prod_sense = 1;
         else tick();
      end
      n_checks++;
      if (on_bad != 0) begin
         n_fail++;
         $display("FAIL water_on: %0d low cycles, want 0", on_bad);
      end
      tick();
      prod_sense = 0;
      n_checks++;
      if (vend_water !== 1'b0 || busy !== 1'b1 || stock_ok_water !== 1'b1) begin
         n_fail++;
         $display("FAIL water_gap: vend=%b busy=%b ok=%b want 0 1 1",
                  vend_water, busy, stock_ok_water);
      end
      tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL water_idle: busy=%b want 0", busy);
      end
   endtask

   task automatic test_coin_order();
      int seq[$];
      int gaps[$];
      int on_cnt, off_cnt, both;
      change10 = 1; change5 = 1;
      tick();
      change10 = 0;
      tick();
      change5 = 0;
      on_cnt = 0; off_cnt = 0; both = 0;
      for (int c = 0; c < 60; c++) begin
         if (motor5 && motor10) both++;
         if (motor5 || motor10) begin
            if (on_cnt == 0) begin
               seq.push_back(motor10 ? 10 : 5);
               if (seq.size() > 1) gaps.push_back(off_cnt);
            end
            off_cnt = 0;
            on_cnt++;
            coin_sense = (on_cnt == 3);
         end else begin
            on_cnt = 0;
            coin_sense = 0;
            off_cnt++;
         end
         tick();
      end
      coin_sense = 0;
      n_checks++;
      if (seq.size() != 3 || seq[0] != 10 || seq[1] != 5 || seq[2] != 5) begin
         n_fail++;
         $display("FAIL coin_order: got %p want '{10,5,5}", seq);
      end
      n_checks++;
      if (gaps.size() != 2 || gaps[0] != 2 || gaps[1] != 2 || both != 0) begin
         n_fail++;
         $display("FAIL coin_gap: gaps=%p both=%0d want '{2,2} 0", gaps, both);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL coin_drained: busy=%b want 0", busy);
      end
   endtask

   task automatic test_coffee_sellout();
      bit ok;
      int seen;
      for (int i = 1; i <= 8; i++) begin
         vend_one(2, 0, ok);
         n_checks++;
         if (!ok || stock_ok_coffee !== (i < 8)) begin
            n_fail++;
            $display("FAIL coffee_vend%0d: ok=%b stock_ok=%b want 1 %b",
                     i, ok, stock_ok_coffee, (i < 8));
         end
      end
      drop_coffee = 1;
      tick();
      drop_coffee = 0;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         if (vend_coffee || busy) seen++;
         tick();
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL coffee_empty_ignored: %0d active cycles want 0", seen);
      end
   endtask

   task automatic test_coke_timeout();
      int cnt, n, held_bad;
      drop_coke = 1;
      tick();
      drop_coke = 0;
      tick();
      cnt = 0; n = 0;
      while (vend_coke && n < 40) begin cnt++; tick(); n++; end
      n_checks++;
      if (cnt != 15 || fault !== 1'b1 || vend_coke !== 1'b0) begin
         n_fail++;
         $display("FAIL coke_timeout: on=%0d fault=%b vend=%b want 15 1 0",
                  cnt, fault, vend_coke);
      end
      held_bad = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (fault !== 1'b1 || vend_coke !== 1'b0 || busy !== 1'b1) held_bad++;
      end
      n_checks++;
      if (held_bad != 0) begin
         n_fail++;
         $display("FAIL coke_fault_held: %0d bad cycles want 0", held_bad);
      end
      clear_fault = 1;
      tick();
      clear_fault = 0;
      tick();
      n_checks++;
      if (vend_coke !== 1'b1 || fault !== 1'b0) begin
         n_fail++;
         $display("FAIL coke_retry: vend=%b fault=%b want 1 0", vend_coke, fault);
      end
      tick(); tick();
      prod_sense = 1;
      tick();
      prod_sense = 0;
      n = 0;
      while (busy && n < 10) begin tick(); n++; end
      n_checks++;
      if (vend_coke !== 1'b0 || fault !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL coke_done: vend=%b fault=%b busy=%b want 0 0 0",
                  vend_coke, fault, busy);
      end
   endtask

   task automatic test_pend_saturation_and_reset();
      int n, on, cnt, seen;
      change5 = 1;
      tick();
      change5 = 0;
      n = 0;
      while (!fault && n < 40) begin tick(); n++; end
      n_checks++;
      if (fault !== 1'b1 || motor5 !== 1'b0) begin
         n_fail++;
         $display("FAIL coin5_timeout: fault=%b motor5=%b want 1 0", fault, motor5);
      end
      for (int i = 0; i < 15; i++) begin
         change5 = 1; tick(); change5 = 0; tick();
      end
      n_checks++;
      if (fault !== 1'b1 || busy !== 1'b1 || motor5 !== 1'b0) begin
         n_fail++;
         $display("FAIL pend5_sat_fault: fault=%b busy=%b motor5=%b want 1 1 0",
                  fault, busy, motor5);
      end
      clear_fault = 1;
      tick();
      clear_fault = 0;
      cnt = 0; on = 0;
      for (int c = 0; c < 200; c++) begin
         if (motor5) begin
            if (on == 0) cnt++;
            on++;
            coin_sense = (on == 3);
         end else begin
            on = 0;
            coin_sense = 0;
         end
         tick();
      end
      coin_sense = 0;
      n_checks++;
      if (cnt != 15 || busy !== 1'b0 || fault !== 1'b0) begin
         n_fail++;
         $display("FAIL pend5_drain: coins=%0d busy=%b fault=%b want 15 0 0",
                  cnt, busy, fault);
      end
      change5 = 1; tick(); change5 = 0;
      change5 = 1; tick(); change5 = 0;
      n = 0;
      while (!motor5 && n < 10) begin tick(); n++; end
      tick();
      #2 rst_n = 0;
      #1;
      n_checks++;
      if (motor5 !== 1'b0 || busy !== 1'b0 || fault !== 1'b0 || stock_ok_coffee !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset: motor5=%b busy=%b fault=%b ok_coffee=%b want 0 0 0 1",
                  motor5, busy, fault, stock_ok_coffee);
      end
      @(posedge clk);
      #3 rst_n = 1;
      tick();
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         if (motor5 || busy) seen++;
         tick();
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL reset_discard: %0d active cycles want 0", seen);
      end
   endtask

   task automatic test_restock_race();
      bit ok;
      int bad;
      bad = 0;
      for (int i = 0; i < 5; i++) begin vend_one(0, 0, ok); if (!ok) bad++; end
      vend_one(0, 1, ok);
      if (!ok) bad++;
      for (int i = 0; i < 7; i++) begin vend_one(0, 0, ok); if (!ok) bad++; end
      n_checks++;
      if (bad != 0 || stock_ok_water !== 1'b1) begin
         n_fail++;
         $display("FAIL restock_wins: bad=%0d stock_ok=%b want 0 1", bad, stock_ok_water);
      end
      vend_one(0, 0, ok);
      n_checks++;
      if (!ok || stock_ok_water !== 1'b0) begin
         n_fail++;
         $display("FAIL restock_last: ok=%b stock_ok=%b want 1 0", ok, stock_ok_water);
      end
   endtask

   initial begin
      test_reset();
      test_water_dispense();
      test_coin_order();
      test_coffee_sellout();
      test_coke_timeout();
      test_pend_saturation_and_reset();
      test_restock_race();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: time %0t exceeded limit", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
